// File: rtl/dice_roll_sequencer_if.sv
// Handshake bundle between the roll sequencer and its surroundings.
// The master drives tick/roll/result_ack; the sequencer (slave) drives step and status.
interface dice_roll_sequencer_if;
   logic       tick;
   logic       roll;
   logic       result_ack;
   logic       step;
   logic       busy;
   logic       result_valid;
   logic [7:0] step_count;

   modport master (
      output tick, roll, result_ack,
      input  step, busy, result_valid, step_count
   );

   modport slave (
      input  tick, roll, result_ack,
      output step, busy, result_valid, step_count
   );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Spin sequencer for the BCD die: fast steps while roll is held, a decelerating
// coast after release, then a parked result held until acknowledged.
module dice_roll_sequencer #(
   parameter int FAST_GAP    = 1,
   parameter int COAST_STEPS = 4,
   parameter int GAP_W       = 5
) (
   input logic                 clk,
   input logic                 rst_n,
   dice_roll_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SPIN, COAST, DONE} state_t;

   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_FAST  = GAP_W'(FAST_GAP);
   localparam logic [GAP_W-1:0] GAP_COAST = GAP_W'(FAST_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_NEXT  = GAP_W'(FAST_GAP + 2);
   localparam logic [3:0]       LAST_IDX  = 4'(COAST_STEPS);

   state_t           state;
   logic             roll_d;
   logic [GAP_W-1:0] gcnt;
   logic [3:0]       cidx;
   logic             rise;
   logic             tick_ok;
   logic             gap_hit;
   logic [7:0]       count_inc;

   assign rise      = bus.roll & ~roll_d;
   // A tick landing on a step cycle is dropped so step can never stretch.
   assign tick_ok   = bus.tick & ~bus.step;
   assign gap_hit   = (gcnt <= GAP_ONE);
   assign count_inc = (bus.step_count == 8'hFF) ? bus.step_count : bus.step_count + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         roll_d           <= 1'b1;
         gcnt             <= '0;
         cidx             <= '0;
         bus.step         <= 1'b0;
         bus.busy         <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.step_count   <= '0;
      end else begin
         roll_d   <= bus.roll;
         bus.step <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state          <= SPIN;
                  bus.busy       <= 1'b1;
                  gcnt           <= GAP_FAST;
                  bus.step_count <= '0;
               end
            end
            SPIN: begin
               if (tick_ok) begin
                  if (gap_hit) begin
                     bus.step       <= 1'b1;
                     bus.step_count <= count_inc;
                  end
                  if (bus.roll) begin
                     gcnt <= gap_hit ? GAP_FAST : gcnt - GAP_ONE;
                  end else begin
                     state <= COAST;
                     gcnt  <= GAP_COAST;
                     cidx  <= '0;
                  end
               end
            end
            COAST: begin
               if (rise) begin
                  state <= SPIN;
                  gcnt  <= GAP_FAST;
               end else if (bus.step && cidx == LAST_IDX) begin
                  state            <= DONE;
                  bus.busy         <= 1'b0;
                  bus.result_valid <= 1'b1;
               end else if (tick_ok) begin
                  if (gap_hit) begin
                     bus.step       <= 1'b1;
                     bus.step_count <= count_inc;
                     cidx           <= cidx + 4'd1;
                     // Each coast pulse widens the next gap by one tick.
                     gcnt           <= GAP_NEXT + GAP_W'(cidx);
                  end else begin
                     gcnt <= gcnt - GAP_ONE;
                  end
               end
            end
            DONE: begin
               if (rise) begin
                  state            <= SPIN;
                  bus.busy         <= 1'b1;
                  bus.result_valid <= 1'b0;
                  gcnt             <= GAP_FAST;
                  bus.step_count   <= '0;
               end else if (bus.result_ack) begin
                  state            <= IDLE;
                  bus.result_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
